// File: rtl/bbc_keyboard_scanner.sv
// bbc_keyboard_scanner: VIA port A / CA2 keyboard matrix with autoscan, direct poll and PS/2 event updates.
// Optional macro KBD_DIP_EN makes row 0, columns 2..9 read-only start-up links taken from DIP_LINKS.
module bbc_keyboard_scanner #(
    parameter int         NUM_COLS  = 10,
    parameter logic [7:0] DIP_LINKS = 8'h00
) (
    input  logic       clk,
    input  logic       nRESET,
    input  logic       clk_en,
    input  logic       nKBEN,
    input  logic [6:0] PA_IN,
    output logic       PA7_OUT,
    output logic       CA2_OUT,
    output logic       nBREAK,
    input  logic       key_valid,
    output logic       key_ready,
    input  logic       key_make,
    input  logic [3:0] key_col,
    input  logic [2:0] key_row,
    input  logic       key_clear
);
`ifdef KBD_DIP_EN
    localparam bit DIP_EN = 1'b1;
`else
    localparam bit DIP_EN = 1'b0;
`endif
    localparam logic [4:0] NC   = 5'(NUM_COLS);
    localparam logic [3:0] LAST = 4'(NUM_COLS - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t     state, state_nxt;
    logic [3:0] clr_idx, col;
    logic [7:0] mtx [16];
    logic       run, brk, fire;

    function automatic logic in_rng(input logic [3:0] c);
        return {1'b0, c} < NC;
    endfunction

    function automatic logic is_link(input logic [3:0] c, input logic [2:0] r);
        return DIP_EN && r == 3'd0 && c >= 4'd2 && c <= 4'd9;
    endfunction

    always_ff @(posedge clk) begin
        if (!nRESET) state <= IDLE;
        else         state <= state_nxt;
    end

    // CLEAR walks every column once; the last wipe coincides with the return to IDLE
    always_comb begin
        state_nxt = (state == IDLE) ? (key_clear ? CLEAR : IDLE)
                                    : (clr_idx == LAST ? IDLE : CLEAR);
    end

    always_comb begin
        key_ready = run && state == IDLE && !key_clear;
    end

    assign fire   = key_valid && key_ready;
    assign nBREAK = ~brk;

    always_ff @(posedge clk) begin
        if (!nRESET) begin
            for (int i = 0; i < 16; i++) mtx[i] <= '0;
            run     <= 1'b0;
            brk     <= 1'b0;
            clr_idx <= '0;
            col     <= '0;
            PA7_OUT <= 1'b0;
            CA2_OUT <= 1'b0;
        end else begin
            run     <= 1'b1;
            clr_idx <= (state == CLEAR) ? clr_idx + 4'd1 : 4'd0;
            if (state == CLEAR) begin
                mtx[clr_idx] <= '0;
                brk          <= 1'b0;
            end else if (fire) begin
                if (key_col == 4'hF)
                    brk <= key_make;
                else if (in_rng(key_col) && !is_link(key_col, key_row))
                    mtx[key_col][key_row] <= key_make;
            end
            col     <= !nKBEN ? PA_IN[3:0] : clk_en ? (col >= LAST ? 4'd0 : col + 4'd1) : col;
            CA2_OUT <= in_rng(col) && |mtx[col][7:1];
            PA7_OUT <= in_rng(PA_IN[3:0]) &&
                       (is_link(PA_IN[3:0], PA_IN[6:4]) ? DIP_LINKS[3'(PA_IN[3:0] - 4'd2)]
                                                        : mtx[PA_IN[3:0]][PA_IN[6:4]]);
        end
    end
endmodule

// File: tb/tb_bbc_keyboard_scanner.sv
// tb_bbc_keyboard_scanner: directed scenarios plus random traffic against a cycle-level matrix model.
module tb_bbc_keyboard_scanner;
    localparam int         NC  = 10;
    localparam logic [7:0] DIP = 8'hA5;

    logic       clk = 1'b0, nRESET = 1'b0, clk_en = 1'b0, nKBEN = 1'b1;
    logic [6:0] PA_IN = '0;
    logic       PA7_OUT, CA2_OUT, nBREAK, key_ready;
    logic       key_valid = 1'b0, key_make = 1'b0, key_clear = 1'b0;
    logic [3:0] key_col = '0;
    logic [2:0] key_row = '0;

    int tests = 0, fails = 0;

    bit m [NC][8];
    bit brk_m, run_m, primed;
    int cnt_m, clear_left, exp_pa7, exp_ca2;

    bbc_keyboard_scanner #(.NUM_COLS(NC), .DIP_LINKS(DIP)) dut (
        .clk(clk), .nRESET(nRESET), .clk_en(clk_en), .nKBEN(nKBEN), .PA_IN(PA_IN),
        .PA7_OUT(PA7_OUT), .CA2_OUT(CA2_OUT), .nBREAK(nBREAK),
        .key_valid(key_valid), .key_ready(key_ready), .key_make(key_make),
        .key_col(key_col), .key_row(key_row), .key_clear(key_clear)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s @%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    function automatic bit link(input int c, input int r);
`ifdef KBD_DIP_EN
        return r == 0 && c >= 2 && c <= 9;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit key_at(input int c, input int r);
        if (c >= NC) return 1'b0;
        return link(c, r) ? DIP[c-2] : m[c][r];
    endfunction

    // One clock: inputs are already set; check handshake, advance model, check registered outputs
    task automatic step();
        bit rdy, any;
        @(negedge clk);
        rdy = run_m && clear_left == 0 && !key_clear;
        #1;
        if (primed) chk("key_ready", key_ready, rdy);
        if (!nRESET) begin
            foreach (m[c, r]) m[c][r] = 1'b0;
            brk_m = 0; run_m = 0; cnt_m = 0; clear_left = 0; exp_pa7 = 0; exp_ca2 = 0;
        end else begin
            exp_pa7 = key_at(int'(PA_IN[3:0]), int'(PA_IN[6:4]));
            any = 0;
            if (cnt_m < NC) for (int r = 1; r < 8; r++) any |= m[cnt_m][r];
            exp_ca2 = any;
            if (clear_left > 0) begin
                for (int r = 0; r < 8; r++) m[NC-clear_left][r] = 1'b0;
                brk_m = 0;
                clear_left--;
            end else if (key_clear) clear_left = NC;
            else if (rdy && key_valid) begin
                if (key_col == 4'hF) brk_m = key_make;
                else if (key_col < NC && !link(key_col, key_row)) m[key_col][key_row] = key_make;
            end
            if (!nKBEN) cnt_m = int'(PA_IN[3:0]);
            else if (clk_en) cnt_m = (cnt_m >= NC - 1) ? 0 : cnt_m + 1;
            run_m = 1;
        end
        @(posedge clk);
        #1;
        primed = 1;
        chk("PA7_OUT", PA7_OUT, exp_pa7);
        chk("CA2_OUT", CA2_OUT, exp_ca2);
        chk("nBREAK", nBREAK, !brk_m);
        if (!nRESET) chk("key_ready_rst", key_ready, 1'b0);
    endtask

    task automatic ev(input bit mk, input int c, input int r);
        key_valid = 1; key_make = mk; key_col = 4'(c); key_row = 3'(r);
        step();
        key_valid = 0;
    endtask

    initial begin
        primed = 0;
        run_m = 0;
        nRESET = 0;
        repeat (3) step();
        nRESET = 1;
        repeat (2) step();
        // autoscan with (3,5) down across a full wrap
        ev(1, 3, 5);
        nKBEN = 1;
        for (int i = 0; i < 12; i++) begin
            clk_en = 1; step(); clk_en = 0; step();
        end
        // direct polls, including an out-of-range column
        nKBEN = 0;
        PA_IN = 7'h53; step(); step();
        PA_IN = 7'h0C; step(); step();
        PA_IN = 7'h02; step(); step();
        PA_IN = 7'h03; step(); step();
        // clear with an event offered in the same cycle
        ev(1, 0, 1); ev(1, 9, 7); ev(1, 15, 0); ev(1, 4, 0); ev(0, 2, 0);
        key_clear = 1; key_valid = 1; key_make = 1; key_col = 4'd6; key_row = 3'd6;
        step();
        key_clear = 1;
        step();
        key_clear = 0;
        repeat (10) step();
        key_valid = 0;
        for (int i = 0; i < 80; i++) begin
            PA_IN = 7'(i); step();
        end
        // row 0 only must never raise CA2
        nKBEN = 1;
        ev(1, 4, 0);
        for (int i = 0; i < 11; i++) begin
            clk_en = 1; step();
        end
        clk_en = 0;
        nKBEN = 0; PA_IN = 7'h04; step(); step();
        for (int n = 0; n < 4000; n++) begin
            nRESET    = ($urandom_range(0, 299) != 0);
            key_valid = 1'($urandom_range(0, 1));
            key_make  = 1'($urandom_range(0, 2) != 0);
            key_col   = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, NC - 1)) : 4'($urandom_range(0, 15));
            key_row   = 3'($urandom_range(0, 7));
            key_clear = ($urandom_range(0, 59) == 0);
            clk_en    = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 29) == 0) nKBEN = ~nKBEN;
            PA_IN     = {3'($urandom_range(0, 7)), ($urandom_range(0, 7) != 0) ? 4'($urandom_range(0, NC - 1)) : 4'($urandom_range(0, 15))};
            step();
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
